// File: rtl/decode_issue_unit.sv
// Registered RV32I(+M) decode/issue stage between IF and ID/EX.
// Accepts instructions over valid/ready and flags illegal encodings.
// The decoded control bundle is held in an output register that can be flushed.
// Saturating counters track accepted and illegal instructions.
module decode_issue_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int ALU_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_load_npc,
  output logic             out_mem_to_reg,
  output logic             out_alu_src1,
  output logic [2:0]       out_reg_write,
  output logic [3:0]       out_mem_write,
  output logic [1:0]       out_reg_read,
  output logic [2:0]       out_branch_type,
  output logic [ALU_W-1:0] out_alu_ctrl,
  output logic [1:0]       out_alu_src2,
  output logic [2:0]       out_imm_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Register write modes, branch codes, immediate types and ALU codes
  localparam logic [2:0] RW_NO = 3'd0, RW_LB = 3'd1, RW_LH = 3'd2, RW_LW = 3'd3,
                         RW_LBU = 3'd4, RW_LHU = 3'd5;
  localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3,
                         BR_BLTU = 3'd4, BR_BGE = 3'd5, BR_BGEU = 3'd6;
  localparam logic [2:0] IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
                         IMM_U = 3'd4, IMM_J = 3'd5;
  localparam logic [4:0] ALU_SLL = 5'd0, ALU_SRL = 5'd1, ALU_SRA = 5'd2,
                         ALU_ADD = 5'd3, ALU_SUB = 5'd4, ALU_XOR = 5'd5,
                         ALU_OR = 5'd6, ALU_AND = 5'd7, ALU_SLT = 5'd8,
                         ALU_SLTU = 5'd9, ALU_LUI = 5'd10, ALU_MBASE = 5'h10;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP = 7'b0110011, OPC_FENCE = 7'b0001111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_M = 7'b0000001;

  typedef struct packed {
    logic             jal;
    logic             jalr;
    logic             load_npc;
    logic             mem_to_reg;
    logic             alu_src1;
    logic [2:0]       reg_write;
    logic [3:0]       mem_write;
    logic [1:0]       reg_read;
    logic [2:0]       branch_type;
    logic [ALU_W-1:0] alu_ctrl;
    logic [1:0]       alu_src2;
    logic [2:0]       imm_type;
    logic             illegal;
  } bundle_t;

  logic [6:0] opcode_s, funct7_s;
  logic [2:0] funct3_s;
  logic [4:0] rd_s;
  logic       unused_fields_s;
  logic       illegal_s, accept_s;
  bundle_t    dec_s, new_bundle_s;

  bundle_t          bundle_q, bundle_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, icnt_q, icnt_d;

  assign opcode_s        = in_instr[6:0];
  assign rd_s            = in_instr[11:7];
  assign funct3_s        = in_instr[14:12];
  assign funct7_s        = in_instr[31:25];
  assign unused_fields_s = ^in_instr[24:15];

  // Combinational decode of the raw instruction into a control bundle
  always_comb begin
    dec_s     = '0;
    illegal_s = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (opcode_s)
        OPC_LUI: begin
          dec_s.reg_write = RW_LW;
          dec_s.alu_ctrl  = ALU_W'(ALU_LUI);
          dec_s.alu_src2  = 2'b10;
          dec_s.imm_type  = IMM_U;
        end
        OPC_AUIPC: begin
          dec_s.reg_write = RW_LW;
          dec_s.alu_ctrl  = ALU_W'(ALU_ADD);
          dec_s.alu_src1  = 1'b1;
          dec_s.alu_src2  = 2'b10;
          dec_s.imm_type  = IMM_U;
        end
        OPC_JAL: begin
          dec_s.jal       = 1'b1;
          dec_s.load_npc  = 1'b1;
          dec_s.reg_write = RW_LW;
          dec_s.imm_type  = IMM_J;
        end
        OPC_JALR: begin
          dec_s.jalr      = 1'b1;
          dec_s.load_npc  = 1'b1;
          dec_s.reg_write = RW_LW;
          dec_s.reg_read  = 2'b10;
          dec_s.alu_ctrl  = ALU_W'(ALU_ADD);
          dec_s.alu_src2  = 2'b10;
          dec_s.imm_type  = IMM_I;
        end
        OPC_BRANCH: begin
          dec_s.reg_read = 2'b11;
          dec_s.imm_type = IMM_B;
          case (funct3_s)
            3'b000:  dec_s.branch_type = BR_BEQ;
            3'b001:  dec_s.branch_type = BR_BNE;
            3'b100:  dec_s.branch_type = BR_BLT;
            3'b101:  dec_s.branch_type = BR_BGE;
            3'b110:  dec_s.branch_type = BR_BLTU;
            3'b111:  dec_s.branch_type = BR_BGEU;
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec_s.mem_to_reg = 1'b1;
          dec_s.reg_read   = 2'b10;
          dec_s.alu_ctrl   = ALU_W'(ALU_ADD);
          dec_s.alu_src2   = 2'b10;
          dec_s.imm_type   = IMM_I;
          case (funct3_s)
            3'b000:  dec_s.reg_write = RW_LB;
            3'b001:  dec_s.reg_write = RW_LH;
            3'b010:  dec_s.reg_write = RW_LW;
            3'b100:  dec_s.reg_write = RW_LBU;
            3'b101:  dec_s.reg_write = RW_LHU;
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_STORE: begin
          dec_s.reg_read = 2'b11;
          dec_s.alu_ctrl = ALU_W'(ALU_ADD);
          dec_s.alu_src2 = 2'b10;
          dec_s.imm_type = IMM_S;
          case (funct3_s)
            3'b000:  dec_s.mem_write = 4'b0001;
            3'b001:  dec_s.mem_write = 4'b0011;
            3'b010:  dec_s.mem_write = 4'b1111;
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_OPIMM: begin
          dec_s.reg_write = RW_LW;
          dec_s.reg_read  = 2'b10;
          dec_s.alu_src2  = 2'b10;
          dec_s.imm_type  = IMM_I;
          case (funct3_s)
            3'b000: dec_s.alu_ctrl = ALU_W'(ALU_ADD);
            3'b010: dec_s.alu_ctrl = ALU_W'(ALU_SLT);
            3'b011: dec_s.alu_ctrl = ALU_W'(ALU_SLTU);
            3'b100: dec_s.alu_ctrl = ALU_W'(ALU_XOR);
            3'b110: dec_s.alu_ctrl = ALU_W'(ALU_OR);
            3'b111: dec_s.alu_ctrl = ALU_W'(ALU_AND);
            3'b001: begin
              dec_s.alu_ctrl = ALU_W'(ALU_SLL);
              dec_s.alu_src2 = 2'b01;
              illegal_s      = (funct7_s != F7_BASE);
            end
            3'b101: begin
              dec_s.alu_ctrl = (funct7_s == F7_ALT) ? ALU_W'(ALU_SRA) : ALU_W'(ALU_SRL);
              dec_s.alu_src2 = 2'b01;
              illegal_s      = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
            end
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_OP: begin
          dec_s.reg_write = RW_LW;
          dec_s.reg_read  = 2'b11;
          dec_s.imm_type  = IMM_R;
          case (funct7_s)
            F7_BASE: begin
              case (funct3_s)
                3'b000:  dec_s.alu_ctrl = ALU_W'(ALU_ADD);
                3'b001:  dec_s.alu_ctrl = ALU_W'(ALU_SLL);
                3'b010:  dec_s.alu_ctrl = ALU_W'(ALU_SLT);
                3'b011:  dec_s.alu_ctrl = ALU_W'(ALU_SLTU);
                3'b100:  dec_s.alu_ctrl = ALU_W'(ALU_XOR);
                3'b101:  dec_s.alu_ctrl = ALU_W'(ALU_SRL);
                3'b110:  dec_s.alu_ctrl = ALU_W'(ALU_OR);
                default: dec_s.alu_ctrl = ALU_W'(ALU_AND);
              endcase
            end
            F7_ALT: begin
              case (funct3_s)
                3'b000:  dec_s.alu_ctrl = ALU_W'(ALU_SUB);
                3'b101:  dec_s.alu_ctrl = ALU_W'(ALU_SRA);
                default: illegal_s = 1'b1;
              endcase
            end
            F7_M: begin
              if (ENABLE_M) begin
                dec_s.alu_ctrl = ALU_W'(ALU_MBASE | {2'b00, funct3_s});
              end else begin
                illegal_s = 1'b1;
              end
            end
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_FENCE: dec_s = '0;
        default:   illegal_s = 1'b1;
      endcase
    end
  end

  // Writes to x0 are discarded; illegal encodings collapse to an inert bundle
  always_comb begin
    new_bundle_s = dec_s;
    if (illegal_s) begin
      new_bundle_s         = '0;
      new_bundle_s.illegal = 1'b1;
    end else if (rd_s == 5'd0) begin
      new_bundle_s.reg_write = RW_NO;
    end else begin
      new_bundle_s.reg_write = dec_s.reg_write;
    end
  end

  assign in_ready = flush | ~valid_q | out_ready;
  assign accept_s = in_valid & in_ready & ~flush;

  // Next-state for the output register and counters; flush wins over everything
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    dcnt_d   = dcnt_q;
    icnt_d   = icnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d  = 1'b1;
      bundle_d = new_bundle_s;
      pc_d     = in_pc;
      instr_d  = in_instr;
      dcnt_d   = (dcnt_q == {CNT_W{1'b1}}) ? dcnt_q : dcnt_q + CNT_W'(1);
      if (new_bundle_s.illegal) begin
        icnt_d = (icnt_q == {CNT_W{1'b1}}) ? icnt_q : icnt_q + CNT_W'(1);
      end else begin
        icnt_d = icnt_q;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output pipeline register and counters with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
      instr_q  <= 32'd0;
      dcnt_q   <= '0;
      icnt_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      dcnt_q   <= dcnt_d;
      icnt_q   <= icnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_instr       = instr_q;
  assign out_jal         = bundle_q.jal;
  assign out_jalr        = bundle_q.jalr;
  assign out_load_npc    = bundle_q.load_npc;
  assign out_mem_to_reg  = bundle_q.mem_to_reg;
  assign out_alu_src1    = bundle_q.alu_src1;
  assign out_reg_write   = bundle_q.reg_write;
  assign out_mem_write   = bundle_q.mem_write;
  assign out_reg_read    = bundle_q.reg_read;
  assign out_branch_type = bundle_q.branch_type;
  assign out_alu_ctrl    = bundle_q.alu_ctrl;
  assign out_alu_src2    = bundle_q.alu_src2;
  assign out_imm_type    = bundle_q.imm_type;
  assign out_illegal     = bundle_q.illegal;
  assign decoded_cnt     = dcnt_q;
  assign illegal_cnt     = icnt_q;

endmodule

// File: tb/tb_decode_issue_unit.sv
// Bench for decode_issue_unit: a scoreboard checks the decoded bundles,
// plus directed checks of handshake, flush, reset and counter saturation.
// The second instance is built without the M extension and with 4-bit counters.
module tb_decode_issue_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        jal, jalr, npc, m2r, src1;
    logic [2:0]  rw;
    logic [3:0]  mw;
    logic [1:0]  rr;
    logic [2:0]  br;
    logic [4:0]  alu;
    logic [1:0]  src2;
    logic [2:0]  imm;
    logic        ill;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] in_instr = 32'd0, in_pc = 32'd0, out_pc, out_instr;
  logic out_jal, out_jalr, out_load_npc, out_mem_to_reg, out_alu_src1, out_illegal;
  logic [2:0] out_reg_write, out_branch_type, out_imm_type;
  logic [3:0] out_mem_write;
  logic [1:0] out_reg_read, out_alu_src2;
  logic [4:0] out_alu_ctrl;
  logic [15:0] decoded_cnt, illegal_cnt;

  logic in_valid2 = 1'b0, out_ready2 = 1'b1, in_ready2, out_valid2;
  logic [31:0] in_instr2 = 32'd0, in_pc2 = 32'd0, out_pc2, out_instr2;
  logic out_jal2, out_jalr2, out_load_npc2, out_mem_to_reg2, out_alu_src12, out_illegal2;
  logic [2:0] out_reg_write2, out_branch_type2, out_imm_type2;
  logic [3:0] out_mem_write2;
  logic [1:0] out_reg_read2, out_alu_src22;
  logic [4:0] out_alu_ctrl2;
  logic [3:0] decoded_cnt2, illegal_cnt2;

  int errors = 0, checks = 0;
  int exp_dcnt = 0, exp_icnt = 0;
  int waited;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_issue_unit #(.XLEN(32), .ENABLE_M(1'b1), .ALU_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_jal(out_jal), .out_jalr(out_jalr),
    .out_load_npc(out_load_npc), .out_mem_to_reg(out_mem_to_reg),
    .out_alu_src1(out_alu_src1), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_reg_read(out_reg_read),
    .out_branch_type(out_branch_type), .out_alu_ctrl(out_alu_ctrl),
    .out_alu_src2(out_alu_src2), .out_imm_type(out_imm_type),
    .out_illegal(out_illegal), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  decode_issue_unit #(.XLEN(32), .ENABLE_M(1'b0), .ALU_W(5), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_instr(in_instr2), .in_pc(in_pc2), .out_ready(out_ready2), .out_valid(out_valid2),
    .out_pc(out_pc2), .out_instr(out_instr2), .out_jal(out_jal2), .out_jalr(out_jalr2),
    .out_load_npc(out_load_npc2), .out_mem_to_reg(out_mem_to_reg2),
    .out_alu_src1(out_alu_src12), .out_reg_write(out_reg_write2),
    .out_mem_write(out_mem_write2), .out_reg_read(out_reg_read2),
    .out_branch_type(out_branch_type2), .out_alu_ctrl(out_alu_ctrl2),
    .out_alu_src2(out_alu_src22), .out_imm_type(out_imm_type2),
    .out_illegal(out_illegal2), .decoded_cnt(decoded_cnt2), .illegal_cnt(illegal_cnt2)
  );

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic jal, input logic jalr, input logic npc,
                              input logic m2r, input logic src1, input logic [2:0] rw,
                              input logic [3:0] mw, input logic [1:0] rr,
                              input logic [2:0] br, input logic [4:0] alu,
                              input logic [1:0] src2, input logic [2:0] imm,
                              input logic ill);
    exp_t e;
    e = '{pc, instr, jal, jalr, npc, m2r, src1, rw, mw, rr, br, alu, src2, imm, ill};
    return e;
  endfunction

  function automatic exp_t bad(input logic [31:0] pc, input logic [31:0] instr);
    return mk(pc, instr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 3'd0,
              5'd0, 2'd0, 3'd0, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to dut and wait (bounded) for the handshake
  task automatic send(input exp_t e, output int n);
    logic acc;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_pc = e.pc;
    in_instr = e.instr;
    while (!acc && n < 20) begin
      #1;
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) begin
      exp_q.push_back(e);
      exp_dcnt++;
      if (e.ill) exp_icnt++;
    end else begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed=no_accept expected=accept");
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare each bundle the downstream actually takes
  always @(negedge clk) begin
    exp_t e, obs;
    if (!rst && out_valid && out_ready && !flush) begin
      obs = {out_pc, out_instr, out_jal, out_jalr, out_load_npc, out_mem_to_reg,
             out_alu_src1, out_reg_write, out_mem_write, out_reg_read,
             out_branch_type, out_alu_ctrl, out_alu_src2, out_imm_type, out_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected: observed=%0h expected=nothing", obs);
      end else begin
        e = exp_q.pop_front();
        assert (obs === e) else begin
          errors++;
          $error("FAIL sb_bundle: observed=%0h expected=%0h", obs, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    exp_t a, b, c;
    // reset state while rst is held
    #3;
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_counters", {decoded_cnt, illegal_cnt}, 96'd0);
    chk("rst_out_pc", 96'(out_pc), 96'd0);
    chk("rst_ctrl", {out_reg_write, out_alu_ctrl, out_illegal}, 96'd0);
    chk("rst_in_ready", 96'(in_ready), 96'd1);
    #9 rst = 1'b0;
    tick();

    // directed decode stream at full throughput
    send(mk(32'h100, 32'h00500093, 0,0,0,0,0, 3'd3, 4'h0, 2'b10, 3'd0, 5'd3,  2'b10, 3'd1, 0), waited);
    chk("addi_out_valid", 96'(out_valid), 96'd1);
    chk("addi_decoded_cnt", 96'(decoded_cnt), 96'd1);
    send(mk(32'h104, 32'h022081B3, 0,0,0,0,0, 3'd3, 4'h0, 2'b11, 3'd0, 5'h10, 2'b00, 3'd0, 0), waited);
    send(mk(32'h108, 32'h008000EF, 1,0,1,0,0, 3'd3, 4'h0, 2'b00, 3'd0, 5'd0,  2'b00, 3'd5, 0), waited);
    send(mk(32'h10C, 32'h0080006F, 1,0,1,0,0, 3'd0, 4'h0, 2'b00, 3'd0, 5'd0,  2'b00, 3'd5, 0), waited);
    send(mk(32'h110, 32'h0020A223, 0,0,0,0,0, 3'd0, 4'hF, 2'b11, 3'd0, 5'd3,  2'b10, 3'd2, 0), waited);
    send(mk(32'h114, 32'h00208463, 0,0,0,0,0, 3'd0, 4'h0, 2'b11, 3'd1, 5'd0,  2'b00, 3'd3, 0), waited);
    send(mk(32'h118, 32'h0000A283, 0,0,0,1,0, 3'd3, 4'h0, 2'b10, 3'd0, 5'd3,  2'b10, 3'd1, 0), waited);
    send(mk(32'h11C, 32'h4020D193, 0,0,0,0,0, 3'd3, 4'h0, 2'b10, 3'd0, 5'd2,  2'b01, 3'd1, 0), waited);
    send(mk(32'h120, 32'h12345237, 0,0,0,0,0, 3'd3, 4'h0, 2'b00, 3'd0, 5'd10, 2'b10, 3'd4, 0), waited);
    send(mk(32'h124, 32'h00001217, 0,0,0,0,1, 3'd3, 4'h0, 2'b00, 3'd0, 5'd3,  2'b10, 3'd4, 0), waited);
    send(mk(32'h128, 32'h0000000F, 0,0,0,0,0, 3'd0, 4'h0, 2'b00, 3'd0, 5'd0,  2'b00, 3'd0, 0), waited);
    send(mk(32'h12C, 32'h000100E7, 0,1,1,0,0, 3'd3, 4'h0, 2'b10, 3'd0, 5'd3,  2'b10, 3'd1, 0), waited);
    send(bad(32'h130, 32'h0020A463), waited);
    send(bad(32'h134, 32'h00000073), waited);
    send(bad(32'h138, 32'h0020B223), waited);
    send(bad(32'h13C, 32'h02009093), waited);
    send(bad(32'h140, 32'h401090B3), waited);
    send(bad(32'h144, 32'h00000001), waited);
    tick();
    tick();
    chk("stream_drained", 96'(exp_q.size()), 96'd0);
    chk("stream_decoded_cnt", 96'(decoded_cnt), 96'(exp_dcnt));
    chk("stream_illegal_cnt", 96'(illegal_cnt), 96'(exp_icnt));

    // backpressure: hold A for two cycles while B waits, then no-bubble drain
    a = mk(32'h200, 32'h00500093, 0,0,0,0,0, 3'd3, 4'h0, 2'b10, 3'd0, 5'd3, 2'b10, 3'd1, 0);
    b = mk(32'h204, 32'h40108133, 0,0,0,0,0, 3'd3, 4'h0, 2'b11, 3'd0, 5'd4, 2'b00, 3'd0, 0);
    c = mk(32'h208, 32'h0000A283, 0,0,0,1,0, 3'd3, 4'h0, 2'b10, 3'd0, 5'd3, 2'b10, 3'd1, 0);
    send(a, waited);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = b.pc;
    in_instr = b.instr;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_in_ready", 96'(in_ready), 96'd0);
      chk("stall_bundle", {out_valid, out_pc, out_instr, out_alu_ctrl}, {1'b1, a.pc, a.instr, 5'd3});
      tick();
    end
    chk("stall_decoded_cnt", 96'(decoded_cnt), 96'(exp_dcnt));
    out_ready = 1'b1;
    send(b, waited);
    chk("release_latency", 96'(waited), 96'd1);
    chk("release_bundle", {out_valid, out_instr}, {1'b1, b.instr});
    chk("release_decoded_cnt", 96'(decoded_cnt), 96'(exp_dcnt));
    send(c, waited);
    chk("next_decoded_cnt", 96'(decoded_cnt), 96'(exp_dcnt));
    tick();
    chk("drain_out_valid", 96'(out_valid), 96'd0);

    // flush beats a simultaneous input handshake and output handshake
    send(a, waited);
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h300;
    in_instr = 32'h00700093;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 96'(out_valid), 96'd0);
    chk("flush_counters", {decoded_cnt, illegal_cnt}, {16'(exp_dcnt), 16'(exp_icnt)});
    if (exp_q.size() > 0) void'(exp_q.pop_back());

    // asynchronous reset between edges drops a held bundle
    out_ready = 1'b0;
    send(b, waited);
    chk("pre_rst_out_valid", 96'(out_valid), 96'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 96'(out_valid), 96'd0);
    chk("async_rst_state", {decoded_cnt, out_instr, out_alu_ctrl}, 96'd0);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_dcnt = 0;
    exp_icnt = 0;
    out_ready = 1'b1;
    tick();

    // ENABLE_M=0: mul is illegal and inert
    in_valid2 = 1'b1;
    in_instr2 = 32'h022081B3;
    tick();
    in_valid2 = 1'b0;
    chk("nom_mul_illegal", {out_valid2, out_illegal2}, 96'b11);
    chk("nom_mul_ctrl", {out_reg_write2, out_mem_write2, out_alu_ctrl2, out_jal2}, 96'd0);
    chk("nom_mul_counts", {decoded_cnt2, illegal_cnt2}, {4'd1, 4'd1});

    // 4-bit counter saturation over 17 accepts, last one illegal
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk("sat_start", 96'(decoded_cnt2), 96'd0);
    for (int i = 0; i < 17; i++) begin
      in_valid2 = 1'b1;
      in_instr2 = (i == 16) ? 32'hFFFF_FFFF : 32'h00500093;
      tick();
      if (i == 14) chk("sat_reach_max", 96'(decoded_cnt2), 96'd15);
    end
    in_valid2 = 1'b0;
    tick();
    chk("sat_decoded_cnt", 96'(decoded_cnt2), 96'd15);
    chk("sat_illegal_cnt", 96'(illegal_cnt2), 96'd1);
    chk("sat_drained", 96'(out_valid2), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_issue_unit.md
Name: decode_issue_unit

Overview:
Registered, parametrised successor to the combinational RV32I instruction decoder. It sits between IF and ID/EX. It accepts instructions over a valid/ready handshake and decodes RV32I, plus optional RV32M. It detects illegal encodings, holds the decoded control bundle in an output pipeline register with flush support, and keeps saturating counters of decoded and illegal instructions.

Parameters:
XLEN, 32, width of PC fields.
ENABLE_M, 1, 1 = decode the RV32M group; 0 = any funct7=0000001 on the OP opcode is illegal.
ALU_W, 5, width of out_alu_ctrl. Existing ALU codes are zero-extended. M ops are 5'h10..5'h17 in the order MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  clock, all state rising-edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  discard the held bundle and any input this cycle.
in_valid  input  1  in_instr/in_pc are valid.
in_ready  output  1  unit can accept this cycle.
in_instr  input  32  raw instruction.
in_pc  input  XLEN  instruction PC.
out_ready  input  1  downstream accepts the bundle.
out_valid  output  1  bundle valid.
out_pc  output  XLEN  registered PC.
out_instr  output  32  registered instruction (for immediate/rd extraction).
out_jal, out_jalr, out_load_npc, out_mem_to_reg, out_alu_src1  output  1 each  decoded controls.
out_reg_write  output  3  register write mode (Parameters.v encodings; 0 = no write).
out_mem_write  output  4  byte-enable write mask.
out_reg_read  output  2  [1]=rs1 used, [0]=rs2 used.
out_branch_type  output  3  Parameters.v branch code; 0 = none.
out_alu_ctrl  output  ALU_W  ALU operation.
out_alu_src2  output  2  00 rs2, 01 shamt, 10 imm.
out_imm_type  output  3  Parameters.v immediate type.
out_illegal  output  1  held instruction is illegal.
decoded_cnt  output  CNT_W  accepted-instruction count.
illegal_cnt  output  CNT_W  accepted-illegal count.

Behaviour:
- Reset (async, immediate): out_valid=0, all control outputs 0, out_pc/out_instr=0, counters=0. Assertion mid-operation drops the held bundle without waiting for a clock.
- Decode is purely combinational from in_instr. It has a full default assignment, so no latches and no X on undefined encodings.
- in_ready = flush | !out_valid | out_ready. This gives full throughput: one instruction per cycle when out_ready stays high.
- Accept = in_valid & in_ready & !flush. On accept the bundle is registered, out_valid=1 next cycle, and latency is 1 cycle.
- If out_valid & out_ready & no accept: out_valid=0.
- While out_valid & !out_ready, all outputs hold stable.
- Flush: out_valid=0 next cycle. Input presented that cycle is dropped and not counted. Flush wins over a simultaneous accept or out handshake.
- Counters increment on accept and saturate at all-ones. illegal_cnt increments only when the accepted instruction is illegal.
- Decode corrections over the previous decoder:
  - JAL/JALR write rd: reg_write=LW, load_npc=1.
  - Branches set reg_read=11. Stores set reg_read=11, reg_write=0.
  - AUIPC and LUI set reg_read=00.
  - rd=x0 forces reg_write=0.
- Illegal conditions:
  - in_instr[1:0]!=11.
  - Unknown opcode.
  - SYSTEM opcode.
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3 >010.
  - OP-IMM SLLI funct7!=0.
  - SRLI/SRAI funct7 not in {0000000, 0100000}.
  - OP funct7 0100000 with funct3 other than 000/101.
  - OP funct7 not in {0000000, 0100000, 0000001}.
  - OP funct7 0000001 when ENABLE_M=0.
- Illegal bundle: out_illegal=1; every control field 0 (no register write, no memory write, no branch, no jump).
- FENCE (0001111) is legal and yields an all-zero NOP bundle.
- M ops: reg_read=11, src2=00, src1=0, imm RTYPE, reg_write=LW.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, reg_write=LW, alu=ADD, src2=10, reg_read=10, imm=ITYPE, illegal=0, decoded_cnt=1.
- mul x3,x1,x2 (0x022081B3): ENABLE_M=1 → alu=5'h10, reg_read=11. ENABLE_M=0 → out_illegal=1, reg_write=0, mem_write=0, illegal_cnt=1.
- jal x1,8 (0x008000EF) → jal=1, load_npc=1, reg_write=LW, reg_read=00. jal x0,8 (0x0080006F) → reg_write=0.
- Back-to-back stream with out_ready=0 for 2 cycles → in_ready=0 and bundle stable for both cycles. Release → the held bundle drains and the next instruction is accepted with no bubble; decoded_cnt increments exactly once per instruction.
- flush asserted in the same cycle as an in_valid handshake → out_valid=0 next cycle, counters unchanged. Async rst pulse between clock edges while out_valid=1 → out_valid=0 before the next edge.
- CNT_W=4, 17 accepted instructions with 0xFFFFFFFF as the last → decoded_cnt=15, illegal_cnt=1, no wrap to 0.
